// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that shares one cacheline-wide DDR port
// between icache line fills and dcache line fills / writebacks. Only one DDR
// transaction is in flight at a time; the owner recorded at grant time
// receives the DDR response.
//
// Handshake: icache/dcache requests are levels that stay high until their
// one-cycle resp pulse. The arbiter raises the DDR strobe (level) from the
// first busy cycle and holds addr/wdata until ddr_arb_resp, which returns the
// FSM to IDLE on that same edge. The requester drops its request the cycle
// after resp.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] icache_arb_addr,
   input  logic                  icache_arb_read,
   output logic [LINE_WIDTH-1:0] arb_icache_rdata,
   output logic                  arb_icache_resp,
   input  logic [ADDR_WIDTH-1:0] dcache_arb_addr,
   input  logic                  dcache_arb_read,
   input  logic                  dcache_arb_write,
   input  logic [LINE_WIDTH-1:0] dcache_arb_wdata,
   output logic [LINE_WIDTH-1:0] arb_dcache_rdata,
   output logic                  arb_dcache_resp,
   output logic [ADDR_WIDTH-1:0] arb_ddr_addr,
   output logic                  arb_ddr_read,
   output logic                  arb_ddr_write,
   output logic [LINE_WIDTH-1:0] arb_ddr_wdata,
   input  logic [LINE_WIDTH-1:0] ddr_arb_rdata,
   input  logic                  ddr_arb_resp,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      ICACHE_BUSY  = 2'd1,
      DCACHE_READ  = 2'd2,
      DCACHE_WRITE = 2'd3
   } state_e;

   // prio_q: 0 = icache wins the next tie, 1 = dcache wins the next tie
   state_e                  state_q, state_d;
   logic                    prio_q, prio_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    dcache_req;

   assign dcache_req = dcache_arb_read | dcache_arb_write;

   // Next-state: grant selection in IDLE, wait for the DDR response when busy
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (icache_arb_read && (!dcache_req || !prio_q)) begin
               state_d = ICACHE_BUSY;
               addr_d  = icache_arb_addr;
               prio_d  = 1'b1;
            end else if (dcache_req) begin
               addr_d = dcache_arb_addr;
               prio_d = 1'b0;
               // Read and write together is illegal; the writeback wins so
               // dirty data is never lost.
               if (dcache_arb_write) begin
                  state_d = DCACHE_WRITE;
                  wdata_d = dcache_arb_wdata;
               end else begin
                  state_d = DCACHE_READ;
               end
            end
         end
         default: begin
            if (ddr_arb_resp) state_d = IDLE;
         end
      endcase
   end

   // State, priority pointer and DDR address/data registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // DDR strobes decode straight from the state register
   always_comb begin
      arb_ddr_read  = (state_q == ICACHE_BUSY) || (state_q == DCACHE_READ);
      arb_ddr_write = (state_q == DCACHE_WRITE);
      arb_ddr_addr  = addr_q;
      arb_ddr_wdata = wdata_q;
      dbg_state     = state_q;
   end

   // Response steering: only the current owner sees ddr_arb_resp
   always_comb begin
      arb_icache_resp  = (state_q == ICACHE_BUSY) && ddr_arb_resp;
      arb_dcache_resp  = ((state_q == DCACHE_READ) || (state_q == DCACHE_WRITE)) && ddr_arb_resp;
      arb_icache_rdata = ddr_arb_rdata;
      arb_dcache_rdata = ddr_arb_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset checks, a table of single transactions,
// hand-written contention and mid-transaction reset sequences, and randomized
// transactions predicted by a round-robin reference model.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   // kind: 0 = icache read, 1 = dcache read, 2 = dcache write
   typedef struct {
      logic          ireq;
      logic          drd;
      logic          dwr;
      logic [AW-1:0] iaddr;
      logic [AW-1:0] daddr;
      logic [LW-1:0] wd;
      int            lat;
      logic [LW-1:0] rd;
      int            exp_kind;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] icache_arb_addr;
   logic          icache_arb_read;
   logic [LW-1:0] arb_icache_rdata;
   logic          arb_icache_resp;
   logic [AW-1:0] dcache_arb_addr;
   logic          dcache_arb_read;
   logic          dcache_arb_write;
   logic [LW-1:0] dcache_arb_wdata;
   logic [LW-1:0] arb_dcache_rdata;
   logic          arb_dcache_resp;
   logic [AW-1:0] arb_ddr_addr;
   logic          arb_ddr_read;
   logic          arb_ddr_write;
   logic [LW-1:0] arb_ddr_wdata;
   logic [LW-1:0] ddr_arb_rdata;
   logic          ddr_arb_resp;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int last_winner;   // 0 = icache served last, 1 = dcache served last
   vec_t vecs[7];

   mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .icache_arb_addr(icache_arb_addr), .icache_arb_read(icache_arb_read),
      .arb_icache_rdata(arb_icache_rdata), .arb_icache_resp(arb_icache_resp),
      .dcache_arb_addr(dcache_arb_addr), .dcache_arb_read(dcache_arb_read),
      .dcache_arb_write(dcache_arb_write), .dcache_arb_wdata(dcache_arb_wdata),
      .arb_dcache_rdata(arb_dcache_rdata), .arb_dcache_resp(arb_dcache_resp),
      .arb_ddr_addr(arb_ddr_addr), .arb_ddr_read(arb_ddr_read),
      .arb_ddr_write(arb_ddr_write), .arb_ddr_wdata(arb_ddr_wdata),
      .ddr_arb_rdata(ddr_arb_rdata), .ddr_arb_resp(ddr_arb_resp),
      .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic drop_all();
      icache_arb_read  = 1'b0;
      dcache_arb_read  = 1'b0;
      dcache_arb_write = 1'b0;
      ddr_arb_resp     = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      drop_all();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One complete transaction: raise requests, expect a grant one cycle
   // later, answer after lat busy cycles, then drop requests.
   task automatic run_txn(input vec_t v);
      logic [AW-1:0] exp_addr;
      logic [LW-1:0] exp_wd;
      int            waited;
      logic          got;
      logic          last;
      exp_addr = (v.exp_kind == 0) ? v.iaddr : v.daddr;
      exp_wd   = v.wd;
      @(negedge clk);
      icache_arb_read  = v.ireq;
      icache_arb_addr  = v.iaddr;
      dcache_arb_read  = v.drd;
      dcache_arb_write = v.dwr;
      dcache_arb_addr  = v.daddr;
      dcache_arb_wdata = v.wd;
      ddr_arb_resp     = 1'b0;
      got    = 1'b0;
      waited = 0;
      for (int w = 0; w < 8 && !got; w++) begin
         @(negedge clk);
         #1;
         waited = w + 1;
         if (arb_ddr_read || arb_ddr_write) got = 1'b1;
      end
      chk("grant_latency", waited, 1);
      if (!got) begin
         drop_all();
         return;
      end
      // Requester inputs wander while busy; the arbiter must ignore them
      icache_arb_addr  = $urandom;
      dcache_arb_addr  = $urandom;
      dcache_arb_wdata = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < v.lat; c++) begin
         last = (c == v.lat - 1);
         if (c > 0) @(negedge clk);
         if (last) begin
            ddr_arb_resp  = 1'b1;
            ddr_arb_rdata = v.rd;
         end
         #1;
         chk("ddr_read_strobe", arb_ddr_read, v.exp_kind != 2);
         chk("ddr_write_strobe", arb_ddr_write, v.exp_kind == 2);
         chk("ddr_addr", arb_ddr_addr, exp_addr);
         if (v.exp_kind == 2) chk("ddr_wdata", arb_ddr_wdata, exp_wd);
         chk("icache_resp", arb_icache_resp, last && (v.exp_kind == 0));
         chk("dcache_resp", arb_dcache_resp, last && (v.exp_kind != 0));
         if (last && v.exp_kind == 0) chk("icache_rdata", arb_icache_rdata, v.rd);
         if (last && v.exp_kind != 0) chk("dcache_rdata", arb_dcache_rdata, v.rd);
      end
      @(negedge clk);
      drop_all();
      #1;
      chk("post_read_strobe", arb_ddr_read, 0);
      chk("post_write_strobe", arb_ddr_write, 0);
      chk("post_resp", {arb_icache_resp, arb_dcache_resp}, 0);
   endtask

   initial begin
      vec_t v;
      int   w;
      logic got;
      // Reset with every request high
      rst = 1'b0;
      icache_arb_read  = 1'b1;
      dcache_arb_read  = 1'b1;
      dcache_arb_write = 1'b1;
      icache_arb_addr  = 32'h0000_4000;
      dcache_arb_addr  = 32'h0000_5000;
      dcache_arb_wdata = {4{32'h1111_2222}};
      ddr_arb_rdata    = '0;
      ddr_arb_resp     = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_strobes", {arb_ddr_read, arb_ddr_write}, 0);
      chk("rst_resps", {arb_icache_resp, arb_dcache_resp}, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_addr", arb_ddr_addr, 0);
      chk("rst_wdata", arb_ddr_wdata, 0);
      // Release with both sides requesting: icache must win first
      @(negedge clk);
      rst = 1'b1;
      dcache_arb_write = 1'b0;
      @(negedge clk);
      #1;
      chk("rel_read", arb_ddr_read, 1);
      chk("rel_addr", arb_ddr_addr, 32'h0000_4000);
      chk("rel_state", dbg_state, 1);
      ddr_arb_resp = 1'b1;
      #1;
      chk("rel_icache_resp", arb_icache_resp, 1);
      chk("rel_dcache_resp", arb_dcache_resp, 0);
      @(negedge clk);
      drop_all();

      // Table of single transactions, pointer at icache after reset
      reset_pulse();
      vecs[0] = '{1, 0, 0, 32'h0000_1230, 32'h0, '0, 5,
                  128'hDEADBEEF_00112233_44556677_8899AABB, 0};
      vecs[1] = '{1, 1, 0, 32'h0000_2000, 32'h0000_3000, '0, 2, {4{32'h0BAD_F00D}}, 1};
      vecs[2] = '{1, 1, 0, 32'h0000_2040, 32'h0000_3040, '0, 3, {4{32'h1234_5678}}, 0};
      vecs[3] = '{0, 0, 1, 32'h0, 32'h0000_8000, {16{8'hA5}}, 4, '0, 2};
      vecs[4] = '{0, 1, 1, 32'h0, 32'h0000_8040, {16{8'h3C}}, 2, '0, 2};
      vecs[5] = '{1, 0, 1, 32'h0000_9000, 32'h0000_A000, {16{8'h77}}, 1, {4{32'hCAFE_0001}}, 0};
      vecs[6] = '{1, 1, 0, 32'h0000_9040, 32'h0000_A040, '0, 6, {4{32'hCAFE_0002}}, 1};
      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // Continuous contention: both held high, grants alternate I, D, I, D
      reset_pulse();
      @(negedge clk);
      icache_arb_read = 1'b1;
      dcache_arb_read = 1'b1;
      icache_arb_addr = 32'h0000_0100;
      dcache_arb_addr = 32'h0000_0200;
      for (int t = 0; t < 4; t++) begin
         got = 1'b0;
         w   = 0;
         while (!got && w < 8) begin
            @(negedge clk);
            ddr_arb_resp = 1'b0;
            #1;
            w++;
            if (arb_ddr_read) got = 1'b1;
         end
         chk("cont_gap", w, (t == 0) ? 1 : 2);
         chk("cont_addr", arb_ddr_addr, (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
         @(negedge clk);
         ddr_arb_resp  = 1'b1;
         ddr_arb_rdata = {4{t[31:0]}};
         #1;
         chk("cont_icache_resp", arb_icache_resp, t % 2 == 0);
         chk("cont_dcache_resp", arb_dcache_resp, t % 2 == 1);
      end
      @(negedge clk);
      drop_all();

      // Reset in the middle of an icache fill, then a late DDR response
      reset_pulse();
      @(negedge clk);
      icache_arb_read = 1'b1;
      icache_arb_addr = 32'h0000_7700;
      @(negedge clk);
      #1;
      chk("mid_busy", arb_ddr_read, 1);
      @(negedge clk);
      rst = 1'b0;
      drop_all();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_strobes", {arb_ddr_read, arb_ddr_write}, 0);
      @(negedge clk);
      ddr_arb_resp = 1'b1;
      #1;
      chk("mid_late_resp", {arb_icache_resp, arb_dcache_resp}, 0);
      @(negedge clk);
      ddr_arb_resp = 1'b0;
      #1;
      chk("mid_idle_state", dbg_state, 0);
      chk("mid_idle_strobes", {arb_ddr_read, arb_ddr_write}, 0);

      // Randomized transactions against the round-robin reference model
      reset_pulse();
      last_winner = 1;
      for (int n = 0; n < 40; n++) begin
         int r;
         int winner;
         r      = $urandom_range(1, 3);
         v.ireq = r[0];
         v.dwr  = r[1] ? 1'($urandom_range(0, 1)) : 1'b0;
         v.drd  = r[1] ? (v.dwr ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
         v.iaddr = {$urandom_range(0, 65535), 16'h0} | 32'h40;
         v.daddr = {$urandom_range(0, 65535), 16'h0} | 32'h80;
         v.wd    = {$urandom, $urandom, $urandom, $urandom};
         v.rd    = {$urandom, $urandom, $urandom, $urandom};
         v.lat   = $urandom_range(1, 6);
         if (v.ireq && r[1]) winner = (last_winner == 0) ? 1 : 0;
         else                winner = v.ireq ? 0 : 1;
         last_winner = winner;
         v.exp_kind  = (winner == 0) ? 0 : (v.dwr ? 2 : 1);
         run_txn(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
